// File: rtl/idct_pkg.sv
// Shared constants and helpers for the dequantiser / Fast_IDCT block path.
package idct_pkg;

  localparam int ML = 16;            // coefficient / output element width (signed)
  localparam int QW = 8;             // quantiser entry width (unsigned)
  localparam int PW = ML + QW + 1;   // signed product width

  // Zigzag stream position -> natural row-major index (standard JPEG order).
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Clamp a full-width product into the signed ML-bit element range.
  function automatic logic [ML-1:0] sat16(input logic signed [PW-1:0] x);
    if (x > $signed({{(QW+2){1'b0}}, {(ML-1){1'b1}}}))
      return {1'b0, {(ML-1){1'b1}}};
    else if (x < $signed({{(QW+2){1'b1}}, {(ML-1){1'b0}}}))
      return {1'b1, {(ML-1){1'b0}}};
    else
      return x[ML-1:0];
  endfunction

  // LSB position of natural element k inside a packed 8x8 block.
  function automatic int blk_lsb(input int k);
    return k * ML;
  endfunction

endpackage

// File: rtl/dq_bank.sv
// One 8x8 coefficient bank: register storage plus a written-mask so that
// positions never written since the bank was opened read back as zero.
module dq_bank
  import idct_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [5:0]        idx,
  input  logic [ML-1:0]     data,
  output logic [64*ML-1:0]  block
);

  logic [ML-1:0] mem [64];
  logic [63:0]   mask;

  // Element storage; stale contents are hidden by the mask, so no reset.
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= data;
  end

  // Written-mask: emptied on reset or when the bank is released for refill.
  always_ff @(posedge clock) begin
    if (reset || clear) mask <= '0;
    else if (we)        mask[idx] <= 1'b1;
  end

  // Packed read with unwritten positions forced to zero.
  always_comb begin
    block = '0;
    for (int k = 0; k < 64; k++)
      block[blk_lsb(k) +: ML] = mask[k] ? mem[k] : '0;
  end

endmodule

// File: rtl/dequant_dezigzag.sv
// Dequantise zigzag-ordered coefficients, reorder into row-major order and
// hand out complete 8x8 blocks from a pair of ping-pong banks.
module dequant_dezigzag
  import idct_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ML-1:0]     in_coef,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              q_we,
  input  logic [5:0]        q_addr,
  input  logic [QW-1:0]     q_data,
  output logic [64*ML-1:0]  out_block,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [QW-1:0]        qtab [64];
  logic [5:0]           wr_pos;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [1:0]           full;
  logic [1:0]           full_nxt;
  logic                 accept;
  logic                 complete;
  logic                 release_blk;
  logic signed [PW-1:0] prod;
  logic [ML-1:0]        wr_val;
  logic [5:0]           wr_idx;
  logic [64*ML-1:0]     bank_block [2];

  assign in_ready    = !full[wr_bank];
  assign out_valid   = full[rd_bank];
  assign accept      = in_valid && in_ready;
  assign complete    = accept && (in_last || (wr_pos == 6'd63));
  assign release_blk = out_valid && out_ready;

  // The beat reads the table combinationally, so a same-cycle write to the
  // same entry is only seen by later beats.
  assign prod   = $signed(in_coef) * $signed({1'b0, qtab[wr_pos]});
  assign wr_val = sat16(prod);
  assign wr_idx = 6'(ZZ[wr_pos]);

  // Quantiser table, identity after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) qtab[i] <= QW'(1);
    end else if (q_we) begin
      qtab[q_addr] <= q_data;
    end
  end

  // Bank occupancy: completion and release always target different banks.
  always_comb begin
    full_nxt = full;
    if (complete)    full_nxt[wr_bank] = 1'b1;
    if (release_blk) full_nxt[rd_bank] = 1'b0;
  end

  // Stream position, bank pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= '0;
      wr_pos  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (complete) begin
        wr_pos  <= '0;
        wr_bank <= !wr_bank;
      end else if (accept) begin
        wr_pos  <= wr_pos + 6'd1;
      end
      if (release_blk) rd_bank <= !rd_bank;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dq_bank u_bank (
      .clock (clock),
      .reset (reset),
      .clear (release_blk && (rd_bank == 1'(b))),
      .we    (accept && (wr_bank == 1'(b))),
      .idx   (wr_idx),
      .data  (wr_val),
      .block (bank_block[b])
    );
  end

  assign out_block = bank_block[rd_bank];

endmodule

// File: tb/tb_dequant_dezigzag.sv
// Directed bench for dequant_dezigzag with a small reference model.
module tb_dequant_dezigzag;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   in_coef = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          q_we = 1'b0;
  logic [5:0]    q_addr = '0;
  logic [7:0]    q_data = '0;
  logic [1023:0] out_block;
  logic          out_valid;
  logic          out_ready = 1'b0;

  dequant_dezigzag dut (
    .clock     (clock),
    .reset     (reset),
    .in_coef   (in_coef),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_we      (q_we),
    .q_addr    (q_addr),
    .q_data    (q_data),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    string name;
    int    k;
    int    exp;
  } ev_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            zz [64];
  int            qm [64];
  int            cur [64];
  int            pos;
  int            stalls;
  logic [1023:0] expq [$];
  logic [1023:0] gotq [$];
  logic [1023:0] snap;

  // Capture each block at the negedge before the handshake edge.
  always @(negedge clock)
    if (!reset && out_valid && out_ready) gotq.push_back(out_block);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int satm(input int c, input int q);
    int p;
    p = c * q;
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  function automatic int elem(input logic [1023:0] b, input int k);
    return int'($signed(b[k*16 +: 16]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      qm[i]  = 1;
      cur[i] = 0;
    end
    pos = 0;
    expq.delete();
    gotq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input int c, input bit last);
    int n;
    logic [1023:0] b;
    in_coef  = 16'(c);
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 3000) begin
      tick();
      n++;
      stalls++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 3000 cycles");
    end
    cur[zz[pos]] = satm(c, qm[pos]);
    if (last || pos == 63) begin
      for (int k = 0; k < 64; k++) begin
        b[k*16 +: 16] = 16'(cur[k]);
        cur[k] = 0;
      end
      expq.push_back(b);
      pos = 0;
    end else begin
      pos++;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic qwrite(input int a, input int d);
    q_we   = 1'b1;
    q_addr = 6'(a);
    q_data = 8'(d);
    tick();
    q_we   = 1'b0;
    qm[a]  = d;
  endtask

  task automatic check_elems(input ev_t t [], input string tag);
    if (gotq.size() == 0) begin
      chk({tag, "_block_present"}, 0, 1);
    end else begin
      foreach (t[i]) chk(t[i].name, elem(gotq[0], t[i].k), t[i].exp);
    end
  endtask

  task automatic cmp_blocks(input string tag);
    logic [1023:0] e;
    logic [1023:0] g;
    int idx;
    tick();
    tick();
    idx = 0;
    while (expq.size() > 0) begin
      if (gotq.size() == 0) begin
        chk({tag, "_missing_blocks"}, 0, expq.size());
        expq.delete();
      end else begin
        e = expq.pop_front();
        g = gotq.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          for (int k = 0; k < 64; k++)
            if (g[k*16 +: 16] !== e[k*16 +: 16]) begin
              $display("FAIL %s_block%0d: element %0d got %0d expected %0d",
                       tag, idx, k, elem(g, k), elem(e, k));
              break;
            end
        end
        idx++;
      end
    end
    chk({tag, "_extra_blocks"}, gotq.size(), 0);
    gotq.delete();
  endtask

  ev_t t1 [];
  ev_t t2 [];
  ev_t t3a [];
  ev_t t3b [];
  ev_t t3c [];
  ev_t t5 [];
  int  nz;

  initial begin
    zz = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
           12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
           35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
           58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    t1  = '{'{"t1_e0", 0, 0}, '{"t1_e1", 1, 1}, '{"t1_e8", 8, 2},
            '{"t1_e16", 16, 3}, '{"t1_e9", 9, 4}, '{"t1_e2", 2, 5},
            '{"t1_e63", 63, 63}};
    t2  = '{'{"t2_e0", 0, -166}, '{"t2_e1", 1, -7}, '{"t2_e8", 8, -4},
            '{"t2_e2", 2, 0}, '{"t2_e63", 63, 0}};
    t3a = '{'{"t3_sat_hi_e0", 0, 32767}, '{"t3_e2", 2, -21}};
    t3b = '{'{"t3_sat_lo_e0", 0, -32768}, '{"t3b_e2", 2, -21}};
    t3c = '{'{"t3_oldq_e0", 0, 1275}};
    t5  = '{'{"t5_e0_qreset", 0, 50}, '{"t5_e16_qreset", 16, 53}};

    model_reset();
    stalls = 0;
    do_reset();

    // reset state
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);

    // 1: identity order and completion latency
    out_ready = 1'b1;
    for (int p = 0; p < 64; p++) begin
      send(p, 1'b0);
      if (p == 62) chk("t1_valid_before_last", out_valid, 0);
    end
    chk("t1_valid_after_last", out_valid, 1);
    tick();
    tick();
    check_elems(t1, "t1");
    cmp_blocks("t1");

    // 2: early end-of-block, then a full block to expose stale data
    send(-166, 1'b0);
    send(-7, 1'b0);
    send(-4, 1'b1);
    tick();
    tick();
    check_elems(t2, "t2");
    if (gotq.size() > 0) begin
      nz = 0;
      for (int k = 0; k < 64; k++) if (elem(gotq[0], k) != 0) nz++;
      chk("t2_nonzero_count", nz, 3);
    end
    cmp_blocks("t2a");
    for (int p = 0; p < 64; p++) send(100 + 3 * p, 1'b0);
    cmp_blocks("t2b");

    // 3: quantise and saturate, plus same-cycle table write
    qwrite(0, 255);
    qwrite(5, 3);
    send(200, 1'b0);
    for (int p = 1; p < 5; p++) send(0, 1'b0);
    send(-7, 1'b0);
    send(0, 1'b1);
    tick();
    tick();
    check_elems(t3a, "t3a");
    cmp_blocks("t3a");
    send(-200, 1'b0);
    for (int p = 1; p < 5; p++) send(0, 1'b0);
    send(-7, 1'b0);
    send(0, 1'b1);
    tick();
    tick();
    check_elems(t3b, "t3b");
    cmp_blocks("t3b");
    q_we   = 1'b1;
    q_addr = 6'd0;
    q_data = 8'd2;
    send(5, 1'b1);
    q_we   = 1'b0;
    qm[0]  = 2;
    tick();
    tick();
    check_elems(t3c, "t3c");
    cmp_blocks("t3c");
    send(5, 1'b1);
    cmp_blocks("t3d");

    // 4: backpressure with three blocks
    out_ready = 1'b0;
    for (int p = 0; p < 64; p++) send(1000 + p, 1'b0);
    chk("t4_in_ready_after_64", in_ready, 1);
    for (int p = 0; p < 64; p++) send(2000 + p, 1'b0);
    chk("t4_in_ready_after_128", in_ready, 0);
    chk("t4_out_valid_stalled", out_valid, 1);
    snap = out_block;
    chk("t4_stalled_block_is_first", (snap === expq[0]) ? 1 : 0, 1);
    repeat (6) tick();
    chk("t4_block_stable", (out_block === snap) ? 1 : 0, 1);
    chk("t4_still_valid", out_valid, 1);
    fork
      begin
        for (int p = 0; p < 64; p++) send(3000 + p, 1'b0);
      end
      begin
        repeat (10) tick();
        out_ready = 1'b1;
      end
    join
    cmp_blocks("t4");

    // 5: reset in the middle of a block with a full block pending
    out_ready = 1'b0;
    qwrite(3, 7);
    for (int p = 0; p < 64; p++) send(4000 + p, 1'b0);
    for (int p = 0; p < 30; p++) send(5000 + p, 1'b0);
    reset = 1'b1;
    tick();
    chk("t5_out_valid_after_reset", out_valid, 0);
    chk("t5_in_ready_after_reset", in_ready, 1);
    reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 64; p++) send(50 + p, 1'b0);
    tick();
    tick();
    check_elems(t5, "t5");
    cmp_blocks("t5");

    // 6: completion and release in the same cycle, then streaming
    out_ready = 1'b0;
    for (int p = 0; p < 64; p++) send(200 + p, 1'b0);
    for (int p = 0; p < 63; p++) send(400 + p, 1'b0);
    out_ready = 1'b1;
    send(463, 1'b1);
    chk("t6_in_ready_after_collide", in_ready, 1);
    chk("t6_out_valid_after_collide", out_valid, 1);
    stalls = 0;
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < 64; p++) send(600 + 200 * b + p, 1'b0);
    chk("t6_stream_stalls", stalls, 0);
    cmp_blocks("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
